// File: rtl/cpuex_mem_pkg.sv
// Shared types and helpers for the load/store unit: RV32I width encodings, FSM states and
// request legality checks.
package cpuex_mem_pkg;

   // RV32I funct3 width encodings for loads and stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StLdCap,
      StStMerge,
      StResp
   } mau_state_e;

   // Byte lane inside a 32-bit word, taken from addr[1:0]
   typedef logic [1:0] lane_t;

   // funct3 legality depends on direction: unsigned widths exist for loads only
   function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      if (we) begin
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      end else begin
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
      end
      return ok;
   endfunction

   // funct3[1:0] carries the access size: 00 byte, 01 half, 10 word
   function automatic logic addr_aligned(input logic [2:0] f3, input lane_t lane);
      logic ok;
      case (f3[1:0])
         2'b00:   ok = 1'b1;
         2'b01:   ok = ~lane[0];
         2'b10:   ok = (lane == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extracts and extends a load from a RAM word, and builds the
// merged word for sub-word stores. One instance serves both the load-capture and merge paths.
module mem_lane_align
   import cpuex_mem_pkg::*;
(
   input  logic [31:0] i_word,
   input  lane_t       i_lane,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_store_word
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Little-endian lane select followed by sign/zero extension for loads
   always_comb begin
      w_byte = i_word[{i_lane, 3'b000} +: 8];
      w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
      case (i_funct3)
         F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_load_data = {24'h000000, w_byte};
         F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
         F3_HU:   o_load_data = {16'h0000, w_half};
         default: o_load_data = i_word;
      endcase
   end

   // Replace only the addressed byte/half of the read word; other lanes pass through
   always_comb begin
      o_store_word = i_word;
      case (i_funct3[1:0])
         2'b00: o_store_word[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
         2'b01: begin
            if (i_lane[1]) begin
               o_store_word[31:16] = i_wdata[15:0];
            end else begin
               o_store_word[15:0] = i_wdata[15:0];
            end
         end
         default: o_store_word = i_wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and a word-wide block RAM with 1-cycle reads.
// One request in flight; sub-word stores are done as read-modify-write.
module mem_access_unit
   import cpuex_mem_pkg::*;
#(
   parameter int unsigned RAM_WORDS = 131072
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err,
   output logic        o_ram_en,
   output logic        o_ram_we,
   output logic        o_ram_rst,
   output logic [31:0] o_ram_addr,
   output logic [31:0] o_ram_di,
   input  logic [31:0] i_ram_dout
);

   mau_state_e  r_state;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_err;

   logic        w_accept;
   logic        w_in_range;
   logic        w_req_ok;
   logic        w_is_sw;
   logic [31:0] w_load_data;
   logic [31:0] w_store_word;

   // Ready is held low while reset is asserted so nothing is accepted during reset
   assign o_req_ready = (r_state == StIdle) && !i_rst;
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_in_range  = {2'b00, i_req_addr[31:2]} < RAM_WORDS;
   assign w_req_ok    = funct3_legal(i_req_we, i_req_funct3) &&
                        addr_aligned(i_req_funct3, i_req_addr[1:0]) && w_in_range;
   assign w_is_sw     = i_req_we && (i_req_funct3 == F3_W);

   assign o_resp_valid = (r_state == StResp);
   assign o_resp_rdata = r_rdata;
   assign o_resp_err   = r_err;
   assign o_ram_rst    = 1'b0;

   mem_lane_align u_lane_align (
      .i_word       (i_ram_dout),
      .i_lane       (r_addr[1:0]),
      .i_funct3     (r_funct3),
      .i_wdata      (r_wdata),
      .o_load_data  (w_load_data),
      .o_store_word (w_store_word)
   );

   // Request/response FSM; latches the request on accept and registers response fields
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_funct3 <= 3'b000;
         r_addr   <= 32'h0;
         r_wdata  <= 32'h0;
         r_rdata  <= 32'h0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_funct3 <= i_req_funct3;
                  r_addr   <= i_req_addr;
                  r_wdata  <= i_req_wdata;
                  r_rdata  <= 32'h0;
                  r_err    <= !w_req_ok;
                  if (!w_req_ok) begin
                     r_state <= StResp;
                  end else if (!i_req_we) begin
                     r_state <= StLdCap;
                  end else if (w_is_sw) begin
                     r_state <= StResp;
                  end else begin
                     r_state <= StStMerge;
                  end
               end
            end
            StLdCap: begin
               r_rdata <= w_load_data;
               r_state <= StResp;
            end
            StStMerge: begin
               r_state <= StResp;
            end
            StResp: begin
               if (i_resp_ready) begin
                  r_rdata <= 32'h0;
                  r_err   <= 1'b0;
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // BRAM port: accept-cycle access driven from the request, merge write from latched regs
   always_comb begin
      o_ram_en   = 1'b0;
      o_ram_we   = 1'b0;
      o_ram_addr = 32'h0;
      o_ram_di   = 32'h0;
      case (r_state)
         StIdle: begin
            if (w_accept && w_req_ok) begin
               o_ram_en   = 1'b1;
               o_ram_we   = w_is_sw;
               o_ram_addr = {i_req_addr[31:2], 2'b00};
               o_ram_di   = w_is_sw ? i_req_wdata : 32'h0;
            end
         end
         StStMerge: begin
            o_ram_en   = 1'b1;
            o_ram_we   = 1'b1;
            o_ram_addr = {r_addr[31:2], 2'b00};
            o_ram_di   = w_store_word;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small block RAM model.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        ram_en;
   logic        ram_we;
   logic        ram_rst;
   logic [31:0] ram_addr;
   logic [31:0] ram_di;
   logic [31:0] ram_dout;

   int n_vec  = 0;
   int n_miss = 0;

   logic [31:0] mem [0:1023];

   always #5 clk = ~clk;

   // Block RAM model: 1-cycle read, output holds when not enabled
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr[11:2]] <= ram_di;
         else        ram_dout <= mem[ram_addr[11:2]];
      end
   end

   mem_access_unit #(.RAM_WORDS(131072)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_we     (req_we),
      .i_req_funct3 (req_funct3),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .o_resp_valid (resp_valid),
      .i_resp_ready (resp_ready),
      .o_resp_rdata (resp_rdata),
      .o_resp_err   (resp_err),
      .o_ram_en     (ram_en),
      .o_ram_we     (ram_we),
      .o_ram_rst    (ram_rst),
      .o_ram_addr   (ram_addr),
      .o_ram_di     (ram_di),
      .i_ram_dout   (ram_dout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full request/response transaction with latency and port checks
   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      int lat;
      logic exp_we;
      exp_we = we && (f3 == 3'b010) && !exp_err;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      #1;
      check({tag, " req_ready"}, 32'(req_ready), 32'd1);
      check({tag, " ram_en"}, 32'(ram_en), 32'(!exp_err));
      check({tag, " ram_we"}, 32'(ram_we), 32'(exp_we));
      @(posedge clk);
      #1;
      // Scramble request inputs after accept; they must have no effect
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'hFFFF_FFFF;
      req_we    = ~we;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " rdata"}, resp_rdata, exp_rdata);
      check({tag, " err"}, 32'(resp_err), 32'(exp_err));
      check({tag, " busy"}, 32'(req_ready), 32'd0);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check({tag, " released"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8081_8283;

      // Reset behaviour
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst req_ready", 32'(req_ready), 32'd0);
      check("rst resp_valid", 32'(resp_valid), 32'd0);
      check("rst ram_en", 32'(ram_en), 32'd0);
      rst = 1'b0;
      #1;
      check("post-rst req_ready", 32'(req_ready), 32'd1);
      check("post-rst rdata", resp_rdata, 32'h0);
      check("post-rst err", 32'(resp_err), 32'd0);
      check("post-rst ram_rst", 32'(ram_rst), 32'd0);

      // Loads with extension
      do_req("LW 0x10",  1'b0, 3'b010, 32'h10, 32'h0, 32'h8081_8283, 1'b0, 2);
      do_req("LB 0x13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
      do_req("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 2);
      do_req("LH 0x12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8081, 1'b0, 2);
      do_req("LHU 0x10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_8283, 1'b0, 2);
      do_req("LB 0x11",  1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFF_FF82, 1'b0, 2);

      // Sub-word stores via read-modify-write
      do_req("SB 0x11",    1'b1, 3'b000, 32'h11, 32'h0000_00AA, 32'h0, 1'b0, 2);
      do_req("LW after SB", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8081_AA83, 1'b0, 2);
      do_req("SH 0x12",    1'b1, 3'b001, 32'h12, 32'h0000_1234, 32'h0, 1'b0, 2);
      do_req("LW after SH", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_AA83, 1'b0, 2);

      // Full-word store
      do_req("SW 0x20",    1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 1);
      do_req("LW 0x20",    1'b0, 3'b010, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

      // Rejected requests
      do_req("LH 0x11 misaligned", 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 1);
      do_req("SW 0x12 misaligned", 1'b1, 3'b010, 32'h12, 32'h5555_5555, 32'h0, 1'b1, 1);
      do_req("L funct3 011",       1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
      do_req("S funct3 100",       1'b1, 3'b100, 32'h10, 32'h0000_0077, 32'h0, 1'b1, 1);
      do_req("LW out of range",    1'b0, 3'b010, 32'h0008_0000, 32'h0, 32'h0, 1'b1, 1);
      do_req("SW 0xFFFFFFFC",      1'b1, 3'b010, 32'hFFFF_FFFC, 32'h1111_1111, 32'h0, 1'b1, 1);
      do_req("LW top word",        1'b0, 3'b010, 32'h0007_FFFC, 32'h0, 32'h0, 1'b0, 2);
      do_req("LW after errors",    1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_AA83, 1'b0, 2);

      // Response held while consumer stalls; new requests ignored
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h10;
      @(posedge clk);
      #1;
      req_addr = 32'h20;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         check("stall resp_valid", 32'(resp_valid), 32'd1);
         check("stall rdata", resp_rdata, 32'h1234_AA83);
         check("stall req_ready", 32'(req_ready), 32'd0);
         check("stall ram_en", 32'(ram_en), 32'd0);
         @(posedge clk);
         #1;
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check("stall release ready", 32'(req_ready), 32'd1);

      // Reset in the middle of a read-modify-write
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h10;
      req_wdata  = 32'h55;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("merge ram_we", 32'(ram_we), 32'd1);
      rst = 1'b1;
      #1;
      check("rst-rmw ram_we", 32'(ram_we), 32'd0);
      check("rst-rmw ram_en", 32'(ram_en), 32'd0);
      check("rst-rmw req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst-rmw ready after", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      check("rst-rmw no resp", 32'(resp_valid), 32'd0);
      do_req("LW after rst-rmw", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_AA83, 1'b0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
